sd_req_arbiter: RTL
===================

SD_REQ_ARBITER -- requirements
Module: sd_req_arbiter

Interface
REQ-001 Parameter NREQ, default 3, number of requesters (0=fdd A, 1=hdd, 2=fdd B).
REQ-002 Parameter TIMEOUT, default 1048576, clk_sys cycles allowed per transaction before abort.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-004 clk_sys  in  1  system clock; all logic on rising edge.
REQ-005 reset  in  1  asynchronous active-high reset.
REQ-006 req_rd  in  NREQ  per-requester read request; level, held until its req_ack rises.
REQ-007 req_wr  in  NREQ  per-requester write request; level, held until its req_ack rises.
REQ-008 req_lba  in  NREQ*32  packed per-requester LBA; slice i = [32*i+31:32*i].
REQ-009 req_buff_din  in  NREQ*8  packed per-requester buffer data, for writes.
REQ-010 req_ack  out  NREQ  sd_ack routed to the granted requester only.
REQ-011 req_buff_wr  out  NREQ  sd_buff_wr gated to the granted requester only.
REQ-012 req_err  out  NREQ  one-cycle pulse to the granted requester on timeout.
REQ-013 sd_lba  out  32  latched LBA of the granted requester.
REQ-014 sd_rd / sd_wr  out  1 each  downstream command strobes.
REQ-015 sd_ack  in  1  downstream acknowledge.
REQ-016 sd_buff_wr  in  1  downstream buffer write strobe.
REQ-017 sd_buff_din  out  8  req_buff_din slice of the granted requester; 8'h00 when idle.
REQ-018 busy  out  1  high in any state other than IDLE.
REQ-019 grant  out  2  index of the current or last granted requester.

Function
REQ-020 FSM states: IDLE, CMD, XFER, DONE.
REQ-021 IDLE: on any (req_rd|req_wr) bit set, select a requester round-robin, searching from last grant+1 modulo NREQ; latch its index, LBA and command; go to CMD.
REQ-022 Latency: sd_rd/sd_wr go high on the clk_sys edge that samples the request, so they are high for the first cycle in CMD.
REQ-023 If req_rd and req_wr are both set for the winner, the read is issued first; the write stays pending for a later grant.
REQ-024 sd_ack edge detection uses a registered copy of sd_ack (old_ack).
REQ-025 CMD: on a rising edge of sd_ack, clear sd_rd/sd_wr and go to XFER.
REQ-026 XFER: on a falling edge of sd_ack, go to DONE.
REQ-027 DONE: lasts exactly one cycle, then returns to IDLE; this is the earliest point for re-arbitration.
REQ-028 If the granted requester drops its request in CMD before sd_ack rises, the request is ignored and the transaction runs to completion.
REQ-029 Requests from ungranted requesters are not acknowledged and wait; no request is lost.
REQ-030 In CMD and XFER a 21-bit counter increments each cycle.
REQ-031 When the counter reaches TIMEOUT-1: clear sd_rd/sd_wr, pulse req_err[grant] for one cycle, go to IDLE.
REQ-032 After a timeout, last grant still advances, so the failed requester does not starve the others.
REQ-033 req_ack, req_buff_wr and sd_buff_din are combinational selects on the grant register; non-granted outputs are 0.

Reset
REQ-034 Reset values: state=IDLE, sd_rd=0, sd_wr=0, sd_lba=0, req_err=0, counter=0, old_ack=0, busy=0, grant=0.
REQ-035 Last-grant register resets to NREQ-1, so requester 0 wins the first simultaneous arbitration.
REQ-036 Reset asserted mid-transaction drops sd_rd/sd_wr immediately, with no req_err pulse.

Structure
REQ-037 Package sd_arb_pkg holds the state enum, the NREQ and TIMEOUT defaults, and the counter width.
REQ-038 Sub-module rr_pick is a combinational round-robin priority encoder: inputs request vector and last grant; outputs index and valid.

Verification
REQ-039 Single read: req_rd[1]=1, req_lba[1]=32'h00000123 -> next cycle sd_rd=1, sd_lba=32'h123, grant=1; on sd_ack rise, sd_rd=0 and req_ack[1]=1; on sd_ack fall, DONE then IDLE.
REQ-040 Contention after reset: req_rd=3'b111 on the same edge -> grant order 0, 1, 2 across three transactions.
REQ-041 Data routing: during grant=2 write, sd_buff_wr pulses -> only req_buff_wr[2] pulses; sd_buff_din equals the req_buff_din[2] slice.
REQ-042 Timeout with TIMEOUT=16: sd_ack held 0 -> sd_wr drops after 16 cycles, req_err[0] pulses once, busy=0.
REQ-043 Reset during XFER -> sd_rd=sd_wr=0, busy=0 asynchronously; a next request from requester 0 is granted first.

Source files
------------

// File: rtl/sd_req_arbiter_pkg.sv
// Shared types and defaults for the SD request arbiter: FSM state encoding,
// requester count, transaction timeout and counter/grant widths.
package sd_arb_pkg;
  localparam int NREQ_DEF    = 3;
  localparam int TIMEOUT_DEF = 1048576;
  localparam int CNT_W       = 21;
  localparam int GRANT_W     = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } arb_state_e;
endpackage

// File: rtl/sd_req_arbiter_if.sv
// Bundle of requester-side and SD-side signals around the arbiter, plus the
// FSM state exposed for observation.
interface sd_req_arbiter_if import sd_arb_pkg::*; #(
  parameter int NREQ = NREQ_DEF
) ();
  // Handshake: req_rd/req_wr are levels held until the requester's req_ack
  // rises; sd_rd/sd_wr stay high until sd_ack rises, and the transfer ends on
  // the following sd_ack fall. req_err pulses one cycle on timeout abort.
  logic [NREQ-1:0]    req_rd;
  logic [NREQ-1:0]    req_wr;
  logic [NREQ*32-1:0] req_lba;
  logic [NREQ*8-1:0]  req_buff_din;
  logic [NREQ-1:0]    req_ack;
  logic [NREQ-1:0]    req_buff_wr;
  logic [NREQ-1:0]    req_err;
  logic [31:0]        sd_lba;
  logic               sd_rd;
  logic               sd_wr;
  logic               sd_ack;
  logic               sd_buff_wr;
  logic [7:0]         sd_buff_din;
  logic               busy;
  logic [GRANT_W-1:0] grant;
  arb_state_e         state;

  modport master (
    output req_rd, req_wr, req_lba, req_buff_din, sd_ack, sd_buff_wr,
    input  req_ack, req_buff_wr, req_err, sd_lba, sd_rd, sd_wr,
           sd_buff_din, busy, grant, state
  );

  modport slave (
    input  req_rd, req_wr, req_lba, req_buff_din, sd_ack, sd_buff_wr,
    output req_ack, req_buff_wr, req_err, sd_lba, sd_rd, sd_wr,
           sd_buff_din, busy, grant, state
  );
endinterface

// File: rtl/sd_req_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: the first requester found
// searching upward from last grant + 1 (wrapping modulo NREQ) wins.
module rr_pick import sd_arb_pkg::*; #(
  parameter int NREQ = NREQ_DEF
) (
  input  logic [NREQ-1:0]    i_req,
  input  logic [GRANT_W-1:0] i_last,
  output logic [GRANT_W-1:0] o_idx,
  output logic               o_valid
);
  logic [GRANT_W-1:0] w_pos;

  // Walk from farthest to nearest so the nearest hit is written last.
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    w_pos   = '0;
    for (int i = NREQ; i >= 1; i--) begin
      w_pos = GRANT_W'((int'(i_last) + i) % NREQ);
      if (i_req[w_pos]) begin
        o_idx   = w_pos;
        o_valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/sd_req_arbiter.sv
// Arbitrates several SD-card block requesters onto one SD command port with
// round-robin grants, per-transaction timeout and grant-routed data strobes.
module sd_req_arbiter import sd_arb_pkg::*; #(
  parameter int NREQ    = NREQ_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic              clk_sys,
  input logic              reset,
  sd_req_arbiter_if.slave  arb_if
);
  arb_state_e         r_state;
  arb_state_e         w_next;
  logic [GRANT_W-1:0] r_grant;
  logic [GRANT_W-1:0] r_last;
  logic [GRANT_W-1:0] w_pick;
  logic               w_pick_vld;
  logic [NREQ-1:0]    w_any;
  logic [31:0]        r_lba;
  logic               r_sd_rd;
  logic               r_sd_wr;
  logic               r_old_ack;
  logic [NREQ-1:0]    r_err;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_ack_rise;
  logic               w_ack_fall;
  logic               w_active;
  logic               w_timeout;
  logic               w_busy;
  logic [NREQ-1:0]    w_req_ack;
  logic [NREQ-1:0]    w_req_buff_wr;
  logic [7:0]         w_buff_din;

  assign w_any = arb_if.req_rd | arb_if.req_wr;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .i_req   (w_any),
    .i_last  (r_last),
    .o_idx   (w_pick),
    .o_valid (w_pick_vld)
  );

  assign w_ack_rise = arb_if.sd_ack & ~r_old_ack;
  assign w_ack_fall = ~arb_if.sd_ack & r_old_ack;
  assign w_active   = (r_state == CMD) || (r_state == XFER);
  assign w_timeout  = w_active && (r_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_pick_vld) w_next = CMD;
      CMD:     if (w_timeout) w_next = IDLE;
               else if (w_ack_rise) w_next = XFER;
      XFER:    if (w_timeout) w_next = IDLE;
               else if (w_ack_fall) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Read wins when a requester has both pending; its write is re-arbitrated later.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_grant   <= '0;
      r_last    <= GRANT_W'(NREQ - 1);
      r_lba     <= '0;
      r_sd_rd   <= 1'b0;
      r_sd_wr   <= 1'b0;
      r_old_ack <= 1'b0;
      r_err     <= '0;
      r_cnt     <= '0;
    end else begin
      r_old_ack <= arb_if.sd_ack;
      r_err     <= '0;
      if (r_state == IDLE && w_pick_vld) begin
        r_grant <= w_pick;
        r_last  <= w_pick;
        r_lba   <= arb_if.req_lba[{w_pick, 5'd0} +: 32];
        r_sd_rd <= arb_if.req_rd[w_pick];
        r_sd_wr <= ~arb_if.req_rd[w_pick];
        r_cnt   <= '0;
      end else if (w_active) begin
        r_cnt <= r_cnt + 1'b1;
        if (w_timeout) begin
          r_sd_rd        <= 1'b0;
          r_sd_wr        <= 1'b0;
          r_err[r_grant] <= 1'b1;
        end else if (r_state == CMD && w_ack_rise) begin
          r_sd_rd <= 1'b0;
          r_sd_wr <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_busy                 = (r_state != IDLE);
    w_req_ack              = '0;
    w_req_buff_wr          = '0;
    w_req_ack[r_grant]     = arb_if.sd_ack;
    w_req_buff_wr[r_grant] = arb_if.sd_buff_wr;
    w_buff_din             = w_busy ? arb_if.req_buff_din[{r_grant, 3'd0} +: 8] : 8'h00;
  end

  assign arb_if.req_ack     = w_req_ack;
  assign arb_if.req_buff_wr = w_req_buff_wr;
  assign arb_if.req_err     = r_err;
  assign arb_if.sd_lba      = r_lba;
  assign arb_if.sd_rd       = r_sd_rd;
  assign arb_if.sd_wr       = r_sd_wr;
  assign arb_if.sd_buff_din = w_buff_din;
  assign arb_if.busy        = w_busy;
  assign arb_if.grant       = r_grant;
  assign arb_if.state       = r_state;
endmodule
